// File: rtl/game_flow_controller.sv
// game_flow_controller: screen-flow FSM with BCD score, high score, lives and difficulty level.
//   Clock         in   system clock
//   Reset         in   asynchronous, active-high
//   i_btn_press   in   single-cycle debounced button pulse
//   i_menu_select in   menu cursor: 0 = Start, 1 = Credits
//   i_scored      in   single-cycle point pulse from the game unit
//   i_missed      in   single-cycle miss pulse from the game unit
//   o_screen      out  0 menu, 1 game, 2 credits, 3 game-over
//   o_pause       out  high in every state except PLAY
//   o_score_bcd   out  current score, digit 0 in [3:0]
//   o_high_bcd    out  high score, retained across games
//   o_lives       out  remaining lives
//   o_level       out  difficulty level
//   o_new_high    out  high score beaten in the last game
//   o_life_lost   out  one-cycle pulse per accepted miss
module game_flow_controller #(
    parameter int LIVES        = 3,
    parameter int SCORE_DIGITS = 2,
    parameter int LEVEL_STEP   = 10,
    parameter int MAX_LEVEL    = 7,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int MISS_CLEARS  = 0,
    localparam int LW = $clog2(LIVES + 1),
    localparam int VW = $clog2(MAX_LEVEL + 1),
    localparam int SW = 4 * SCORE_DIGITS
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          i_btn_press,
    input  logic          i_menu_select,
    input  logic          i_scored,
    input  logic          i_missed,
    output logic [1:0]    o_screen,
    output logic          o_pause,
    output logic [SW-1:0] o_score_bcd,
    output logic [SW-1:0] o_high_bcd,
    output logic [LW-1:0] o_lives,
    output logic [VW-1:0] o_level,
    output logic          o_new_high,
    output logic          o_life_lost
);
    localparam int CW = $clog2(LEVEL_STEP);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {S_MENU, S_CREDITS, S_PLAY, S_PAUSE, S_OVER} state_t;

    state_t        r_state, w_next;
    logic [SW-1:0] r_score, w_score, w_score_inc, r_high, w_high;
    logic [LW-1:0] r_lives, w_lives;
    logic [VW-1:0] r_level, w_level;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [HW-1:0] r_hold, w_hold;
    logic [1:0]    r_screen, w_screen;
    logic          r_pause, r_new_high, w_new_high, r_life_lost, w_life_lost, w_carry;

    // Ripple BCD increment; the final carry doubles as the all-9s saturation flag.
    always_comb begin
        w_carry = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            w_score_inc[4*d +: 4] = !w_carry ? r_score[4*d +: 4] :
                                    (r_score[4*d +: 4] == 4'd9) ? 4'd0 : r_score[4*d +: 4] + 4'd1;
            w_carry = w_carry && (r_score[4*d +: 4] == 4'd9);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_score     = r_score;
        w_high      = r_high;
        w_lives     = r_lives;
        w_level     = r_level;
        w_cnt       = r_cnt;
        w_hold      = r_hold;
        w_new_high  = r_new_high;
        w_life_lost = 1'b0;
        case (r_state)
            S_MENU: if (i_btn_press) begin
                if (i_menu_select) w_next = S_CREDITS;
                else begin
                    w_next     = S_PLAY;
                    w_score    = '0;
                    w_lives    = LW'(LIVES);
                    w_level    = '0;
                    w_cnt      = '0;
                    w_new_high = 1'b0;
                end
            end
            S_CREDITS: if (i_btn_press) w_next = S_MENU;
            S_PLAY: begin
                if (i_btn_press) w_next = S_PAUSE;
                if (i_scored && !w_carry) begin
                    w_score = w_score_inc;
                    w_cnt   = (r_cnt == CW'(LEVEL_STEP - 1)) ? '0 : r_cnt + 1'b1;
                    if (r_cnt == CW'(LEVEL_STEP - 1) && r_level != VW'(MAX_LEVEL)) w_level = r_level + 1'b1;
                end
                // Applied after the score so that a clearing miss overrides a same-cycle point.
                if (i_missed) begin
                    w_life_lost = 1'b1;
                    w_lives     = (r_lives != '0) ? r_lives - 1'b1 : '0;
                    if (MISS_CLEARS != 0) begin
                        w_score = '0;
                        w_cnt   = '0;
                    end
                    if (r_lives <= LW'(1)) begin
                        w_next = S_OVER;
                        w_hold = '0;
                    end
                end
            end
            S_PAUSE: if (i_btn_press) w_next = S_PLAY;
            S_OVER: begin
                // Hold counter is zero only in the first OVER cycle.
                if (r_hold == '0 && r_score > r_high) begin
                    w_high     = r_score;
                    w_new_high = 1'b1;
                end
                if (r_hold != HW'(HOLD_CYCLES)) w_hold = r_hold + 1'b1;
                if (i_btn_press && r_hold == HW'(HOLD_CYCLES)) w_next = S_MENU;
            end
            default: w_next = S_MENU;
        endcase
        w_screen = (w_next == S_OVER) ? 2'd3 : (w_next == S_CREDITS) ? 2'd2 : (w_next == S_MENU) ? 2'd0 : 2'd1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_MENU;
            r_score     <= '0;
            r_high      <= '0;
            r_lives     <= LW'(LIVES);
            r_level     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_screen    <= 2'd0;
            r_pause     <= 1'b1;
            r_new_high  <= 1'b0;
            r_life_lost <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_score     <= w_score;
            r_high      <= w_high;
            r_lives     <= w_lives;
            r_level     <= w_level;
            r_cnt       <= w_cnt;
            r_hold      <= w_hold;
            r_screen    <= w_screen;
            r_pause     <= (w_next != S_PLAY);
            r_new_high  <= w_new_high;
            r_life_lost <= w_life_lost;
        end
    end

    assign o_screen    = r_screen;
    assign o_pause     = r_pause;
    assign o_score_bcd = r_score;
    assign o_high_bcd  = r_high;
    assign o_lives     = r_lives;
    assign o_level     = r_level;
    assign o_new_high  = r_new_high;
    assign o_life_lost = r_life_lost;
endmodule
